// File: rtl/rx_decoder_pkg.sv
// Shared types and position constants for the Hamming(7,4) receive decoder.
// Positions are 1-based codeword positions; bit index = position - 1.
package rx_decoder_pkg;

    typedef logic [6:0] codeword_t;
    typedef logic [3:0] data_t;
    typedef logic [2:0] syndrome_t;

    localparam int PARITY_POS_0 = 1;
    localparam int PARITY_POS_1 = 2;
    localparam int PARITY_POS_2 = 4;

    localparam int DATA_POS_0 = 3;
    localparam int DATA_POS_1 = 5;
    localparam int DATA_POS_2 = 6;
    localparam int DATA_POS_3 = 7;

    localparam codeword_t PARITY_MASK = codeword_t'((1 << (PARITY_POS_0 - 1)) |
                                                    (1 << (PARITY_POS_1 - 1)) |
                                                    (1 << (PARITY_POS_2 - 1)));

    function automatic data_t extract_data(input codeword_t c);
        return {c[DATA_POS_3-1], c[DATA_POS_2-1], c[DATA_POS_1-1], c[DATA_POS_0-1]};
    endfunction

endpackage

// File: rtl/module_rx_decoder_syndrome.sv
// Combinational Hamming(7,4) syndrome: each bit is the parity over the
// positions whose index has that bit set.
module hamming74_syndrome
    import rx_decoder_pkg::*;
(
    input  codeword_t e,
    output syndrome_t syn
);

    assign syn[0] = e[0] ^ e[2] ^ e[4] ^ e[6];
    assign syn[1] = e[1] ^ e[2] ^ e[5] ^ e[6];
    assign syn[2] = e[3] ^ e[4] ^ e[5] ^ e[6];

endmodule

// File: rtl/module_rx_decoder.sv
// Hamming(7,4) receive decoder: combinational syndrome/flag, registered
// corrected data. Optional error counter enabled by RX_DECODER_ERRCNT_EN.
module module_rx_decoder
    import rx_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       e,
    input  logic             in_valid,
    output logic [3:0]       p,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic [3:0]       out_syn
`ifdef RX_DECODER_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    syndrome_t syn;
    codeword_t flip;
    codeword_t corr;
    logic      err_flag;

    hamming74_syndrome u_syndrome (
        .e   (e),
        .syn (syn)
    );

    assign err_flag = |syn;
    assign p        = {err_flag, syn};

    // Syndrome k points at position k, i.e. bit k-1; a zero syndrome flips nothing.
    assign flip = err_flag ? codeword_t'(7'b000_0001 << (syn - 3'd1)) : '0;
    assign corr = e ^ flip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_syn   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= extract_data(corr);
                out_syn  <= p;
            end
        end
    end

`ifdef RX_DECODER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (in_valid && err_flag && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_module_rx_decoder.sv
// Randomized self-checking bench for module_rx_decoder against a positional
// Hamming reference model (syndrome = XOR of the positions holding a 1).
module tb_module_rx_decoder;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       e;
    logic             in_valid;
    logic [3:0]       p;
    logic             out_valid;
    logic [3:0]       out_data;
    logic [3:0]       out_syn;
`ifdef RX_DECODER_ERRCNT_EN
    logic [CNT_W-1:0] err_count;
`endif

    always #5 clk = ~clk;

    module_rx_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e         (e),
        .in_valid  (in_valid),
        .p         (p),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_syn   (out_syn)
`ifdef RX_DECODER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic       m_valid;
    logic [3:0] m_data;
    logic [3:0] m_syn;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_syn(input logic [6:0] w);
        int s = 0;
        for (int k = 1; k <= 7; k++)
            if (w[k-1]) s = s ^ k;
        return s;
    endfunction

    function automatic logic [6:0] ref_correct(input logic [6:0] w);
        logic [6:0] c = w;
        int s = ref_syn(w);
        if (s != 0) c[s-1] = ~c[s-1];
        return c;
    endfunction

    function automatic logic [3:0] ref_data(input logic [6:0] w);
        logic [6:0] c = ref_correct(w);
        return {c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [3:0] ref_p(input logic [6:0] w);
        int s = ref_syn(w);
        return {s != 0, 3'(s)};
    endfunction

    // Drive one cycle, check p combinationally, then registered outputs after the edge.
    task automatic apply(input logic [6:0] w, input logic v, input logic r);
        e        = w;
        in_valid = v;
        rst_n    = r;
        #1;
        chk("p", 32'(p), 32'(ref_p(w)));
        @(posedge clk);
        if (!r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_syn   = '0;
            m_cnt   = 0;
        end else begin
            m_valid = v;
            if (v) begin
                m_data = ref_data(w);
                m_syn  = ref_p(w);
                if (ref_syn(w) != 0 && m_cnt < CNT_MAX) m_cnt++;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_syn", 32'(out_syn), 32'(m_syn));
`ifdef RX_DECODER_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(m_cnt));
`endif
    endtask

    task automatic directed(input string tag, input logic [6:0] w,
                            input logic [3:0] exp_p, input logic [3:0] exp_data);
        apply(w, 1'b1, 1'b1);
        chk({tag, "_syn"}, 32'(out_syn), 32'(exp_p));
        chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [6:0] w;
        m_valid  = 1'b0;
        m_data   = '0;
        m_syn    = '0;
        m_cnt    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        e        = '0;
        @(posedge clk);
        #1;

        apply(7'h00, 1'b0, 1'b0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);

        directed("clean",   7'b1100110, 4'b0000, 4'b1101);
        directed("bit5",    7'b1110110, 4'b1101, 4'b1101);
        directed("parity1", 7'b1100111, 4'b1001, 4'b1101);
        directed("pos7",    7'b0100110, 4'b1111, 4'b1101);

        apply(7'b1100110, 1'b0, 1'b1);
        chk("hold_data", 32'(out_data), 32'b1101);
        chk("hold_valid", 32'(out_valid), 32'd0);

        apply(7'b1110110, 1'b1, 1'b0);
        chk("rst_prio_valid", 32'(out_valid), 32'd0);
        chk("rst_prio_data", 32'(out_data), 32'd0);
`ifdef RX_DECODER_ERRCNT_EN
        chk("rst_prio_cnt", 32'(err_count), 32'd0);
`endif

        for (int i = 0; i < 5; i++) apply(7'b1110110, 1'b1, 1'b1);
`ifdef RX_DECODER_ERRCNT_EN
        chk("cnt_saturated", 32'(err_count), 32'd3);
`endif
        chk("b2b_data", 32'(out_data), 32'b1101);

        for (int i = 0; i < 500; i++) begin
            w = 7'($urandom);
            if ($urandom_range(0, 2) == 0) w = ref_correct(w);
            apply(w, $urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
